// File: rtl/alu_issue_ctrl_if.sv
// Issue-stage bundle: instruction handshake, register load/debug ports and the alu-facing signals.
interface alu_issue_ctrl_if #(
   parameter int unsigned BUS_WIDTH  = 32,
   parameter int unsigned REG_ADDR_W = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            in_opcode;
   logic [REG_ADDR_W-1:0] in_rd;
   logic [REG_ADDR_W-1:0] in_rs0;
   logic [REG_ADDR_W-1:0] in_rs1;
   logic                  ld_valid;
   logic [REG_ADDR_W-1:0] ld_addr;
   logic [BUS_WIDTH-1:0]  ld_data;
   logic [REG_ADDR_W-1:0] rd_addr;
   logic [BUS_WIDTH-1:0]  rd_data;
   logic [3:0]            alu_opcode;
   logic [BUS_WIDTH-1:0]  alu_num_0;
   logic [BUS_WIDTH-1:0]  alu_num_1;
   logic [BUS_WIDTH-1:0]  alu_num_out;
   logic                  alu_over;
   logic                  alu_zero;
   logic                  alu_greater;
   logic                  alu_equal;
   logic [3:0]            flags_q;
   logic                  done;

   modport slave (
      input  in_valid, in_opcode, in_rd, in_rs0, in_rs1,
      input  ld_valid, ld_addr, ld_data, rd_addr,
      input  alu_num_out, alu_over, alu_zero, alu_greater, alu_equal,
      output in_ready, rd_data, alu_opcode, alu_num_0, alu_num_1, flags_q, done
   );

   modport master (
      output in_valid, in_opcode, in_rd, in_rs0, in_rs1,
      output ld_valid, ld_addr, ld_data, rd_addr,
      output alu_num_out, alu_over, alu_zero, alu_greater, alu_equal,
      input  in_ready, rd_data, alu_opcode, alu_num_0, alu_num_1, flags_q, done
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage around an external combinational alu: one instruction in flight,
// IDLE -> EXEC -> WB, with an 8-entry register file (r0 reads zero) and a status register.
module alu_issue_ctrl #(
   parameter int unsigned BUS_WIDTH  = 32,
   parameter int unsigned REG_ADDR_W = 3
) (
   input logic             clk,
   input logic             rst,
   alu_issue_ctrl_if.slave io_bus
);
   localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

   typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic [3:0]            r_opcode;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [BUS_WIDTH-1:0]  r_op0;
   logic [BUS_WIDTH-1:0]  r_op1;
   logic [BUS_WIDTH-1:0]  r_result;
   logic [3:0]            r_flag_tmp;
   logic [3:0]            r_flags;
   logic                  r_done;
   logic [BUS_WIDTH-1:0]  r_regs [NumRegs];

   logic                  w_accept;
   logic                  w_op_valid;
   logic                  w_wb_we;
   logic                  w_ld_we;
   logic [BUS_WIDTH-1:0]  w_rs0_data;
   logic [BUS_WIDTH-1:0]  w_rs1_data;

   assign w_rs0_data     = (io_bus.in_rs0 == '0) ? '0 : r_regs[io_bus.in_rs0];
   assign w_rs1_data     = (io_bus.in_rs1 == '0) ? '0 : r_regs[io_bus.in_rs1];
   assign io_bus.rd_data = (io_bus.rd_addr == '0) ? '0 : r_regs[io_bus.rd_addr];
   assign io_bus.flags_q = r_flags;
   assign io_bus.done    = r_done;

   assign w_accept = (r_state == StIdle) && io_bus.in_valid;

   // NUL and undefined opcodes retire without touching registers or flags.
   always_comb begin
      w_op_valid = 1'b0;
      case (r_opcode)
         4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011: w_op_valid = 1'b1;
         default:                                     w_op_valid = 1'b0;
      endcase
   end

   assign w_wb_we = (r_state == StWb) && w_op_valid && (r_rd != '0);
   // Writeback wins over a same-address load on the same edge.
   assign w_ld_we = io_bus.ld_valid && (io_bus.ld_addr != '0) &&
                    !(w_wb_we && (io_bus.ld_addr == r_rd));

   always_comb begin
      w_state_next      = r_state;
      io_bus.in_ready   = 1'b0;
      io_bus.alu_opcode = '0;
      io_bus.alu_num_0  = '0;
      io_bus.alu_num_1  = '0;
      unique case (r_state)
         StIdle: begin
            io_bus.in_ready = 1'b1;
            if (io_bus.in_valid) w_state_next = StExec;
         end
         StExec: begin
            io_bus.alu_opcode = r_opcode;
            io_bus.alu_num_0  = r_op0;
            io_bus.alu_num_1  = r_op1;
            w_state_next      = StWb;
         end
         StWb: begin
            io_bus.alu_opcode = r_opcode;
            io_bus.alu_num_0  = r_op0;
            io_bus.alu_num_1  = r_op1;
            w_state_next      = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_opcode   <= '0;
         r_rd       <= '0;
         r_op0      <= '0;
         r_op1      <= '0;
         r_result   <= '0;
         r_flag_tmp <= '0;
         r_flags    <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= (r_state == StWb);
         if (w_accept) begin
            r_opcode <= io_bus.in_opcode;
            r_rd     <= io_bus.in_rd;
            r_op0    <= w_rs0_data;
            r_op1    <= w_rs1_data;
         end
         if (r_state == StExec) begin
            r_result   <= io_bus.alu_num_out;
            r_flag_tmp <= {io_bus.alu_over, io_bus.alu_zero, io_bus.alu_greater,
                           io_bus.alu_equal};
         end
         if ((r_state == StWb) && w_op_valid) r_flags <= r_flag_tmp;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NumRegs; i++) r_regs[i] <= '0;
      end else begin
         if (w_ld_we) r_regs[io_bus.ld_addr] <= io_bus.ld_data;
         if (w_wb_we) r_regs[r_rd] <= r_result;
      end
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural alu hooked to the alu-facing signals.
module tb_alu_issue_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_issue_ctrl_if #(.BUS_WIDTH(32), .REG_ADDR_W(3)) bus ();

   alu_issue_ctrl #(.BUS_WIDTH(32), .REG_ADDR_W(3)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   localparam logic [3:0] OpNul = 4'b0000, OpAdd = 4'b0001, OpSub = 4'b0010;
   localparam logic [3:0] OpAnd = 4'b0100, OpOr = 4'b1000, OpXor = 4'b0011;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] w_res;
   logic        w_ovf;
   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (bus.alu_opcode)
         OpAdd: begin
            w_res = bus.alu_num_0 + bus.alu_num_1;
            w_ovf = (bus.alu_num_0[31] == bus.alu_num_1[31]) && (w_res[31] != bus.alu_num_0[31]);
         end
         OpSub: begin
            w_res = bus.alu_num_0 - bus.alu_num_1;
            w_ovf = (bus.alu_num_0[31] != bus.alu_num_1[31]) && (w_res[31] != bus.alu_num_0[31]);
         end
         OpAnd:   w_res = bus.alu_num_0 & bus.alu_num_1;
         OpOr:    w_res = bus.alu_num_0 | bus.alu_num_1;
         OpXor:   w_res = bus.alu_num_0 ^ bus.alu_num_1;
         default: w_res = '0;
      endcase
   end
   assign bus.alu_num_out = w_res;
   assign bus.alu_over    = w_ovf;
   assign bus.alu_zero    = (w_res == '0);
   assign bus.alu_greater = (bus.alu_num_0 > bus.alu_num_1);
   assign bus.alu_equal   = (bus.alu_num_0 == bus.alu_num_1);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [2:0] addr, input logic [31:0] data);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = addr;
      bus.ld_data  = data;
      tick();
      bus.ld_valid = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
      bus.rd_addr = addr;
      #1;
      check(tag, bus.rd_data, exp);
   endtask

   task automatic set_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs0,
                            input logic [2:0] rs1);
      bus.in_opcode = op;
      bus.in_rd     = rd;
      bus.in_rs0    = rs0;
      bus.in_rs1    = rs1;
   endtask

   // Returns with done high (or after a bounded wait), latency counted including the accept edge.
   task automatic wait_done(input string tag);
      int cnt = 1;
      while (!bus.done && cnt < 10) begin
         tick();
         cnt++;
      end
      check({tag, "_lat"}, 32'(cnt), 32'd3);
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs0, input logic [2:0] rs1);
      set_instr(op, rd, rs0, rs1);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      wait_done(tag);
   endtask

   initial begin
      int dones;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      set_instr(OpNul, 3'd0, 3'd0, 3'd0);
      bus.ld_valid = 1'b0;
      bus.ld_addr  = '0;
      bus.ld_data  = '0;
      bus.rd_addr  = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_flags", 32'(bus.flags_q), 32'd0);
      check("rst_aluop", 32'(bus.alu_opcode), 32'd0);

      ld(3'd1, 32'hfffffff1);
      ld(3'd2, 32'h00000001);
      run_op("add", OpAdd, 3'd3, 3'd1, 3'd2);
      rd_check("add_r3", 3'd3, 32'hfffffff2);
      check("add_flags", 32'(bus.flags_q), 32'h2);
      tick();
      check("done_pulse", 32'(bus.done), 32'd0);

      ld(3'd5, 32'h0000ffff);
      run_op("sub", OpSub, 3'd4, 3'd5, 3'd5);
      rd_check("sub_r4", 3'd4, 32'h00000000);
      check("sub_flags", 32'(bus.flags_q), 32'h5);

      ld(3'd1, 32'h7e7e7e7e);
      ld(3'd2, 32'h5555aaaa);
      run_op("and", OpAnd, 3'd3, 3'd1, 3'd2);
      rd_check("and_r3", 3'd3, 32'h54542a2a);
      run_op("or", OpOr, 3'd3, 3'd1, 3'd2);
      rd_check("or_r3", 3'd3, 32'h7f7ffefe);
      run_op("xor", OpXor, 3'd3, 3'd1, 3'd2);
      rd_check("xor_r3", 3'd3, 32'h2b2bd4d4);
      check("xor_flags", 32'(bus.flags_q), 32'h2);

      run_op("nul", OpNul, 3'd3, 3'd1, 3'd2);
      rd_check("nul_r3", 3'd3, 32'h2b2bd4d4);
      check("nul_flags", 32'(bus.flags_q), 32'h2);
      run_op("undef", 4'b1111, 3'd3, 3'd1, 3'd2);
      rd_check("undef_r3", 3'd3, 32'h2b2bd4d4);

      // Reset with ADD r3 in EXEC, after flags were made non-zero
      run_op("sub2", OpSub, 3'd4, 3'd5, 3'd5);
      check("sub2_flags", 32'(bus.flags_q), 32'h5);
      tick();
      set_instr(OpAdd, 3'd3, 3'd1, 3'd2);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("exec_ready", 32'(bus.in_ready), 32'd0);
      check("exec_aluop", 32'(bus.alu_opcode), 32'(OpAdd));
      check("exec_num0", bus.alu_num_0, 32'h7e7e7e7e);
      rst = 1'b1;
      #1;
      check("arst_ready", 32'(bus.in_ready), 32'd1);
      check("arst_flags", 32'(bus.flags_q), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      rd_check("arst_r3", 3'd3, 32'h0);
      rd_check("arst_r1", 3'd1, 32'h0);
      tick();
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.done) dones++;
      end
      check("arst_nodone", 32'(dones), 32'd0);
      rd_check("arst_r3_after", 3'd3, 32'h0);

      // Back-to-back: second instruction accepted in the done cycle, reads written r3
      ld(3'd1, 32'hfffffff1);
      ld(3'd2, 32'h00000001);
      set_instr(OpAdd, 3'd3, 3'd1, 3'd2);
      bus.in_valid = 1'b1;
      tick();
      set_instr(OpAdd, 3'd4, 3'd3, 3'd3);
      tick();
      tick();
      check("b2b_done", 32'(bus.done), 32'd1);
      check("b2b_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("b2b_acc", 32'(bus.in_ready), 32'd0);
      wait_done("b2b");
      rd_check("b2b_r3", 3'd3, 32'hfffffff2);
      rd_check("b2b_r4", 3'd4, 32'hffffffe4);

      // WB vs load on the same edge: same address -> WB wins
      tick();
      set_instr(OpAdd, 3'd6, 3'd1, 3'd2);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      ld(3'd6, 32'h12345678);
      check("wbld_done", 32'(bus.done), 32'd1);
      rd_check("wbld_r6", 3'd6, 32'hfffffff2);

      // Different addresses on the same edge -> both written
      set_instr(OpXor, 3'd6, 3'd1, 3'd4);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      ld(3'd7, 32'hcafef00d);
      rd_check("wbld2_r6", 3'd6, 32'h00000015);
      rd_check("wbld2_r7", 3'd7, 32'hcafef00d);

      ld(3'd0, 32'hffffffff);
      rd_check("r0_zero", 3'd0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
